// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults and the hardwired-zero register address for regfile_mp.
package regfile_pkg;
    localparam int DEF_XLEN = 64;
    localparam int DEF_NREG = 32;
    localparam int REG_ZERO = 0;
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register pending-write (busy) tracking with alloc/clear/flush and a registered busy count.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter  int NREG = DEF_NREG,
    localparam int AW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          alloc_v,
    input  logic [AW-1:0] alloc_a,
    input  logic          flush,
    input  logic          clr0_v,
    input  logic [AW-1:0] clr0_a,
    input  logic          clr1_v,
    input  logic [AW-1:0] clr1_a,
    input  logic [AW-1:0] ra1,
    input  logic [AW-1:0] ra2,
    output logic          busy1,
    output logic          busy2,
    output logic [AW:0]   busy_cnt
);
    logic [NREG-1:0] r_busy;
    logic [NREG-1:0] w_busy_nxt;
    logic [AW:0]     w_cnt_nxt;

    // Priority low to high: write clears, alloc set, flush; register 0 never goes busy.
    always_comb begin
        w_busy_nxt = r_busy;
        if (clr0_v) w_busy_nxt[clr0_a] = 1'b0;
        if (clr1_v) w_busy_nxt[clr1_a] = 1'b0;
        if (alloc_v) w_busy_nxt[alloc_a] = 1'b1;
        if (flush) w_busy_nxt = '0;
        w_busy_nxt[REG_ZERO] = 1'b0;
        w_cnt_nxt = '0;
        for (int i = 0; i < NREG; i++) w_cnt_nxt = w_cnt_nxt + {{AW{1'b0}}, w_busy_nxt[i]};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy   <= '0;
            busy_cnt <= '0;
        end else begin
            r_busy   <= w_busy_nxt;
            busy_cnt <= w_cnt_nxt;
        end
    end

    assign busy1 = r_busy[ra1];
    assign busy2 = r_busy[ra2];
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: 2-write/2-read register file with x0 hardwired to zero and a busy scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write data onto the read ports.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter  int XLEN = DEF_XLEN,
    parameter  int NREG = DEF_NREG,
    localparam int AW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            we0,
    input  logic            we1,
    input  logic [AW-1:0]   wa0,
    input  logic [AW-1:0]   wa1,
    input  logic [XLEN-1:0] wd0,
    input  logic [XLEN-1:0] wd1,
    input  logic [AW-1:0]   ra1,
    input  logic [AW-1:0]   ra2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    input  logic            alloc_v,
    input  logic [AW-1:0]   alloc_a,
    input  logic            flush,
    output logic            busy1,
    output logic            busy2,
    output logic [AW:0]     busy_cnt
);
    logic [XLEN-1:0] r_regs [NREG];
    logic            w_we0;
    logic            w_we1;

    assign w_we0 = we0 && (wa0 != AW'(REG_ZERO));
    assign w_we1 = we1 && (wa1 != AW'(REG_ZERO));

    // Port 1 wins a same-address collision; r_regs[0] is only ever reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
        end else begin
            for (int i = 0; i < NREG; i++)
                if (w_we1 && wa1 == AW'(i)) r_regs[i] <= wd1;
                else if (w_we0 && wa0 == AW'(i)) r_regs[i] <= wd0;
        end
    end

`ifdef REGFILE_BYPASS_EN
    assign rd1 = reset ? '0 : (w_we1 && wa1 == ra1) ? wd1 : (w_we0 && wa0 == ra1) ? wd0 : r_regs[ra1];
    assign rd2 = reset ? '0 : (w_we1 && wa1 == ra2) ? wd1 : (w_we0 && wa0 == ra2) ? wd0 : r_regs[ra2];
`else
    assign rd1 = reset ? '0 : r_regs[ra1];
    assign rd2 = reset ? '0 : r_regs[ra2];
`endif

    regfile_scoreboard #(.NREG(NREG)) u_sb (
        .clk      (clk),
        .reset    (reset),
        .alloc_v  (alloc_v),
        .alloc_a  (alloc_a),
        .flush    (flush),
        .clr0_v   (w_we0),
        .clr0_a   (wa0),
        .clr1_v   (w_we1),
        .clr1_a   (wa1),
        .ra1      (ra1),
        .ra2      (ra2),
        .busy1    (busy1),
        .busy2    (busy2),
        .busy_cnt (busy_cnt)
    );
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed and random stimulus against an array-based reference model of regfile_mp.
module tb_regfile_mp;
    logic        clk = 1'b0;
    logic        reset;
    logic        we0, we1, alloc_v, flush;
    logic [4:0]  wa0, wa1, ra1, ra2, alloc_a;
    logic [63:0] wd0, wd1;
    logic [63:0] rd1, rd2;
    logic        busy1, busy2;
    logic [5:0]  busy_cnt;

    logic [63:0] m_regs [32];
    bit          m_busy [32];
    int          m_cnt;
    int          checks = 0;
    int          failures = 0;

    regfile_mp dut (
        .clk(clk), .reset(reset), .we0(we0), .we1(we1), .wa0(wa0), .wa1(wa1),
        .wd0(wd0), .wd1(wd1), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
        .alloc_v(alloc_v), .alloc_a(alloc_a), .flush(flush),
        .busy1(busy1), .busy2(busy2), .busy_cnt(busy_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle();
        we0 = 0; we1 = 0; alloc_v = 0; flush = 0;
        wa0 = 0; wa1 = 0; alloc_a = 0; wd0 = 0; wd1 = 0;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 0;
        end
        m_cnt = 0;
    endtask

    function automatic logic [63:0] exp_rd(input logic [4:0] a);
        if (reset) return '0;
`ifdef REGFILE_BYPASS_EN
        if (a != 0 && we1 && wa1 == a) return wd1;
        if (a != 0 && we0 && wa0 == a) return wd0;
`endif
        return m_regs[a];
    endfunction

    // Reference update for one rising edge, applied from the architectural rules.
    task automatic model_edge();
        if (reset) begin
            model_clear();
            return;
        end
        if (we0 && wa0 != 0 && !(we1 && wa1 == wa0)) m_regs[wa0] = wd0;
        if (we1 && wa1 != 0) m_regs[wa1] = wd1;
        if (flush) begin
            for (int i = 0; i < 32; i++) m_busy[i] = 0;
        end else begin
            if (we0) m_busy[wa0] = 0;
            if (we1) m_busy[wa1] = 0;
            if (alloc_v && alloc_a != 0) m_busy[alloc_a] = 1;
        end
        m_cnt = 0;
        for (int i = 0; i < 32; i++) m_cnt += int'(m_busy[i]);
    endtask

    task automatic compare_all();
        chk("rd1", rd1, exp_rd(ra1));
        chk("rd2", rd2, exp_rd(ra2));
        chk("busy1", 64'(busy1), 64'(reset ? 1'b0 : m_busy[ra1]));
        chk("busy2", 64'(busy2), 64'(reset ? 1'b0 : m_busy[ra2]));
        chk("busy_cnt", 64'(busy_cnt), 64'(m_cnt));
    endtask

    task automatic step();
        #1 compare_all();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic alloc(input logic [4:0] a);
        idle(); alloc_v = 1; alloc_a = a; step();
    endtask

    task automatic wr0(input logic [4:0] a, input logic [63:0] d);
        idle(); we0 = 1; wa0 = a; wd0 = d; step();
    endtask

    initial begin
        idle(); ra1 = 0; ra2 = 0;
        reset = 1; model_clear();
        #2 compare_all();
        @(negedge clk); reset = 0;

        // x0 protection
        idle(); we0 = 1; wa0 = 0; wd0 = '1; alloc_v = 1; alloc_a = 0; ra1 = 0; step();
        idle(); #1 chk("x0_rd", rd1, 64'h0); chk("x0_busy", 64'(busy1), 64'h0); chk("x0_cnt", 64'(busy_cnt), 64'h0);

        // scoreboard alloc/clear/alloc-wins
        alloc(3); alloc(4);
        idle(); #1 chk("sb_cnt2", 64'(busy_cnt), 64'd2);
        wr0(3, 64'h33);
        idle(); ra1 = 3; #1 chk("sb_cnt1", 64'(busy_cnt), 64'd1); chk("sb_busy3", 64'(busy1), 64'h0);
        idle(); alloc_v = 1; alloc_a = 4; we1 = 1; wa1 = 4; wd1 = 64'h44; step();
        idle(); ra1 = 4; #1 chk("sb_busy4", 64'(busy1), 64'h1);

        // flush beats alloc
        alloc(10); alloc(11);
        idle(); #1 chk("fl_pre", 64'(busy_cnt), 64'd3);
        idle(); flush = 1; alloc_v = 1; alloc_a = 9; step();
        idle(); ra1 = 9; #1 chk("fl_cnt", 64'(busy_cnt), 64'd0); chk("fl_busy9", 64'(busy1), 64'h0);

        // write collision
        idle(); we0 = 1; we1 = 1; wa0 = 7; wa1 = 7; wd0 = 64'hAA; wd1 = 64'hBB; step();
        idle(); ra1 = 7; #1 chk("collide", rd1, 64'hBB);

        // bypass
        wr0(6, 64'h11);
        idle(); we0 = 1; wa0 = 6; wd0 = 64'h55; ra2 = 6;
`ifdef REGFILE_BYPASS_EN
        #1 chk("bypass", rd2, 64'h55);
`else
        #1 chk("bypass", rd2, 64'h11);
`endif
        step();
        idle(); #1 chk("bypass_after", rd2, 64'h55);

        // reset mid-run
        alloc(12);
        wr0(5, 64'h1234);
        idle(); ra1 = 5; #1 chk("rst_pre", rd1, 64'h1234);
        reset = 1; model_clear();
        #1 chk("rst_rd", rd1, 64'h0); chk("rst_cnt", 64'(busy_cnt), 64'h0);
        we0 = 1; wa0 = 5; wd0 = 64'hDEAD; alloc_v = 1; alloc_a = 5; step();
        reset = 0; idle(); #1 chk("rst_ign", rd1, 64'h0);

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            if (reset) reset = 0;
            else if ($urandom_range(0, 60) == 0) begin
                reset = 1; model_clear();
            end
            we0 = $urandom_range(0, 2) != 0;
            we1 = $urandom_range(0, 2) == 0;
            wa0 = 5'($urandom_range(0, 31));
            wa1 = $urandom_range(0, 3) == 0 ? wa0 : 5'($urandom_range(0, 31));
            wd0 = {$urandom, $urandom};
            wd1 = {$urandom, $urandom};
            alloc_v = $urandom_range(0, 1) == 1;
            alloc_a = $urandom_range(0, 3) == 0 ? wa1 : 5'($urandom_range(0, 31));
            flush = $urandom_range(0, 20) == 0;
            ra1 = $urandom_range(0, 2) == 0 ? wa0 : 5'($urandom_range(0, 31));
            ra2 = $urandom_range(0, 2) == 0 ? wa1 : 5'($urandom_range(0, 31));
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
